// File: rtl/modulo_gerenciador_rolhas_param.sv
// -----------------------------------------------------------------------------
// modulo_gerenciador_rolhas_param
//
// Cork stock manager for a bottle sealing line. Corks are loaded into a
// secondary stock, moved in bursts of up to LOTE corks into the main stock
// when it runs low, and drawn one at a time from the main stock as bottles
// are sealed. Sealed bottles are counted in dozens, and dozens are counted
// into production lots of LIM_DUZIAS.
//
// Ports
//   clk          : single clock, rising edge
//   clr          : asynchronous active-high reset
//   enable       : 1 = run, 0 = stop (stocks kept, current lot restarted)
//   load_valid   : one-cycle request to add load_qty corks to secondary stock
//   load_qty     : corks offered with load_valid
//   consume      : one-cycle pulse, one bottle sealed (one cork drawn)
//   main_count   : corks in the main stock
//   sec_count    : corks in the secondary stock
//   transferring : high while a transfer burst is active
//   load_ack     : one-cycle pulse, load accepted
//   load_err     : one-cycle pulse, load rejected (would exceed CAP_MAX)
//   ro           : main stock empty
//   low          : main stock below MIN_ROLHAS
//   no_cork      : one-cycle pulse, bottle requested with an empty main stock
//   duzias       : completed dozens in the current lot
//   lote_done    : one-cycle pulse when the lot completes
// All outputs are registered.
// -----------------------------------------------------------------------------
module modulo_gerenciador_rolhas_param #(
  parameter int W          = 7,
  parameter int CAP_MAX    = 99,
  parameter int MIN_ROLHAS = 5,
  parameter int LOTE       = 15,
  parameter int DUZIA      = 12,
  parameter int LIM_DUZIAS = 10,
  parameter int DW         = $clog2(LIM_DUZIAS + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          enable,
  input  logic          load_valid,
  input  logic [W-1:0]  load_qty,
  input  logic          consume,
  output logic [W-1:0]  main_count,
  output logic [W-1:0]  sec_count,
  output logic          transferring,
  output logic          load_ack,
  output logic          load_err,
  output logic          ro,
  output logic          low,
  output logic          no_cork,
  output logic [DW-1:0] duzias,
  output logic          lote_done
);

  localparam int BW = $clog2(DUZIA + 1);

  localparam logic [W-1:0]  CAP_W      = W'(CAP_MAX);
  localparam logic [W-1:0]  MIN_W      = W'(MIN_ROLHAS);
  localparam logic [W-1:0]  LOTE_W     = W'(LOTE);
  localparam logic [W-1:0]  ONE_W      = W'(1);
  localparam logic [W-1:0]  ZERO_W     = W'(0);
  localparam logic [BW-1:0] BOT_LAST   = BW'(DUZIA - 1);
  localparam logic [BW-1:0] BOT_ONE    = BW'(1);
  localparam logic [BW-1:0] BOT_ZERO   = BW'(0);
  localparam logic [DW-1:0] DUZ_LAST   = DW'(LIM_DUZIAS - 1);
  localparam logic [DW-1:0] DUZ_ONE    = DW'(1);
  localparam logic [DW-1:0] DUZ_ZERO   = DW'(0);

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    IDLE     = 2'd1,
    TRANSFER = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  main_r, main_s;
  logic [W-1:0]  sec_r, sec_s;
  logic [W-1:0]  burst_r, burst_s;
  logic [W-1:0]  sec_add_s;
  logic [BW-1:0] bottle_r, bottle_s;
  logic [DW-1:0] duzias_r, duzias_s;
  logic          enable_r;
  logic          transferring_r;
  logic          load_ack_r, load_ack_s;
  logic          load_err_r, load_err_s;
  logic          no_cork_r, no_cork_s;
  logic          lote_done_r, lote_done_s;
  logic          ro_r, low_r;
  logic          run_s, step_s, drawn_s, fit_s;

  // Per-cycle qualifiers: running, transfer step, counted bottle, load fit.
  always_comb begin
    run_s     = enable && (state_r != STOP);
    step_s    = run_s && (state_r == TRANSFER) &&
                (sec_r != ZERO_W) && (main_r < CAP_W);
    drawn_s   = run_s && consume && (main_r != ZERO_W);
    no_cork_s = run_s && consume && (main_r == ZERO_W);
    // Widened by one bit so the sum cannot wrap before the compare.
    fit_s     = ({1'b0, sec_r} + {1'b0, load_qty}) <= {1'b0, CAP_W};
  end

  // Stock arithmetic: load acceptance, transfer step and cork draw.
  always_comb begin
    sec_add_s  = ZERO_W;
    load_ack_s = 1'b0;
    load_err_s = 1'b0;
    sec_s      = sec_r;
    main_s     = main_r;
    if (load_valid) begin
      if (fit_s) begin
        load_ack_s = 1'b1;
        sec_add_s  = load_qty;
      end else begin
        load_err_s = 1'b1;
        sec_add_s  = ZERO_W;
      end
    end else begin
      sec_add_s = ZERO_W;
    end
    // A step only happens with sec_r > 0, so the decrement cannot underflow.
    if (step_s) begin
      sec_s = sec_r + sec_add_s - ONE_W;
    end else begin
      sec_s = sec_r + sec_add_s;
    end
    // A cork arriving and a cork leaving in the same cycle cancel out.
    if (step_s && !drawn_s) begin
      main_s = main_r + ONE_W;
    end else if (!step_s && drawn_s) begin
      main_s = main_r - ONE_W;
    end else begin
      main_s = main_r;
    end
  end

  // FSM next state and burst counter.
  always_comb begin
    state_s = state_r;
    burst_s = burst_r;
    case (state_r)
      STOP: begin
        if (enable) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      IDLE: begin
        if (!enable) begin
          state_s = STOP;
        end else if ((main_r < MIN_W) && (sec_r != ZERO_W)) begin
          state_s = TRANSFER;
          burst_s = ZERO_W;
        end else begin
          state_s = IDLE;
        end
      end
      TRANSFER: begin
        if (!enable) begin
          state_s = STOP;
        end else begin
          if (step_s) begin
            burst_s = burst_r + ONE_W;
          end else begin
            burst_s = burst_r;
          end
          // Exit is judged on the values this cycle leaves behind.
          if ((burst_s == LOTE_W) || (sec_s == ZERO_W) || (main_s == CAP_W)) begin
            state_s = IDLE;
          end else begin
            state_s = TRANSFER;
          end
        end
      end
      default: begin
        state_s = STOP;
        burst_s = ZERO_W;
      end
    endcase
  end

  // Bottle, dozen and lot counting; a stop restarts the current lot.
  always_comb begin
    bottle_s    = bottle_r;
    duzias_s    = duzias_r;
    lote_done_s = 1'b0;
    if (enable_r && !enable) begin
      bottle_s = BOT_ZERO;
      duzias_s = DUZ_ZERO;
    end else if (drawn_s) begin
      if (bottle_r == BOT_LAST) begin
        bottle_s = BOT_ZERO;
        if (duzias_r == DUZ_LAST) begin
          duzias_s    = DUZ_ZERO;
          lote_done_s = 1'b1;
        end else begin
          duzias_s = duzias_r + DUZ_ONE;
        end
      end else begin
        bottle_s = bottle_r + BOT_ONE;
      end
    end else begin
      bottle_s = bottle_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= STOP;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath counters and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_r         <= ZERO_W;
      sec_r          <= ZERO_W;
      burst_r        <= ZERO_W;
      bottle_r       <= BOT_ZERO;
      duzias_r       <= DUZ_ZERO;
      enable_r       <= 1'b0;
      transferring_r <= 1'b0;
      load_ack_r     <= 1'b0;
      load_err_r     <= 1'b0;
      no_cork_r      <= 1'b0;
      lote_done_r    <= 1'b0;
      ro_r           <= 1'b1;
      low_r          <= 1'b1;
    end else begin
      main_r         <= main_s;
      sec_r          <= sec_s;
      burst_r        <= burst_s;
      bottle_r       <= bottle_s;
      duzias_r       <= duzias_s;
      enable_r       <= enable;
      transferring_r <= (state_s == TRANSFER);
      load_ack_r     <= load_ack_s;
      load_err_r     <= load_err_s;
      no_cork_r      <= no_cork_s;
      lote_done_r    <= lote_done_s;
      ro_r           <= (main_s == ZERO_W);
      low_r          <= (main_s < MIN_W);
    end
  end

  assign main_count   = main_r;
  assign sec_count    = sec_r;
  assign transferring = transferring_r;
  assign load_ack     = load_ack_r;
  assign load_err     = load_err_r;
  assign ro           = ro_r;
  assign low          = low_r;
  assign no_cork      = no_cork_r;
  assign duzias       = duzias_r;
  assign lote_done    = lote_done_r;

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// -----------------------------------------------------------------------------
// Bench for modulo_gerenciador_rolhas_param: a stock/lot reference model runs
// in lockstep with the design on every clock, plus a vector table and directed
// sequences for bursts, load limits, lot completion and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_modulo_gerenciador_rolhas_param;

  localparam int W     = 7;
  localparam int CAP   = 99;
  localparam int MIN   = 5;
  localparam int LOTE  = 15;
  localparam int DUZIA = 12;
  localparam int LIM   = 10;
  localparam int DW    = 4;

  // Model modes, named after the operating modes of the line.
  localparam int M_STOP = 0;
  localparam int M_IDLE = 1;
  localparam int M_TR   = 2;

  localparam logic [31:0] RESET_OUTS = {7'd0, 7'd0, 7'd0, 4'd0,
                                        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic          clk = 1'b0;
  logic          clr;
  logic          enable;
  logic          load_valid;
  logic [W-1:0]  load_qty;
  logic          consume;
  logic [W-1:0]  main_count;
  logic [W-1:0]  sec_count;
  logic          transferring;
  logic          load_ack;
  logic          load_err;
  logic          ro;
  logic          low;
  logic          no_cork;
  logic [DW-1:0] duzias;
  logic          lote_done;

  modulo_gerenciador_rolhas_param #(
    .W(W), .CAP_MAX(CAP), .MIN_ROLHAS(MIN), .LOTE(LOTE),
    .DUZIA(DUZIA), .LIM_DUZIAS(LIM)
  ) dut (
    .clk(clk), .clr(clr), .enable(enable), .load_valid(load_valid),
    .load_qty(load_qty), .consume(consume), .main_count(main_count),
    .sec_count(sec_count), .transferring(transferring), .load_ack(load_ack),
    .load_err(load_err), .ro(ro), .low(low), .no_cork(no_cork),
    .duzias(duzias), .lote_done(lote_done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int m_mode, m_main, m_sec, m_burst, m_lot, m_counted;
  bit m_en_prev, m_drawn;
  bit e_ack, e_err, e_nocork, e_lote;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {7'd0, main_count, sec_count, duzias, transferring, load_ack,
            load_err, ro, low, no_cork, lote_done};
  endfunction

  function automatic logic [31:0] model_outs();
    logic [6:0] mm;
    logic [6:0] ms;
    logic [3:0] dz;
    mm = 7'(m_main);
    ms = 7'(m_sec);
    dz = 4'(m_lot / DUZIA);
    return {7'd0, mm, ms, dz, (m_mode == M_TR), e_ack, e_err,
            (m_main == 0), (m_main < MIN), e_nocork, e_lote};
  endfunction

  task automatic model_reset();
    m_mode = M_STOP; m_main = 0; m_sec = 0; m_burst = 0; m_lot = 0;
    m_counted = 0; m_en_prev = 1'b0; m_drawn = 1'b0;
    e_ack = 1'b0; e_err = 1'b0; e_nocork = 1'b0; e_lote = 1'b0;
  endtask

  // One clock of the line, computed from the stock/lot rules on integers.
  task automatic model_step(input bit en, input bit lv, input int lq, input bit cons);
    bit running, moving;
    int add, new_main, new_sec, new_burst, new_mode;
    running  = en && (m_mode != M_STOP);
    moving   = running && (m_mode == M_TR) && (m_sec > 0) && (m_main < CAP);
    m_drawn  = running && cons && (m_main > 0);
    e_nocork = running && cons && (m_main == 0);
    e_ack = 1'b0; e_err = 1'b0; e_lote = 1'b0; add = 0;
    if (lv) begin
      if (m_sec + lq <= CAP) begin e_ack = 1'b1; add = lq; end
      else e_err = 1'b1;
    end
    new_sec   = m_sec + add - int'(moving);
    new_main  = m_main + int'(moving) - int'(m_drawn);
    new_burst = m_burst + int'(moving);
    if (!en) new_mode = M_STOP;
    else if (m_mode == M_STOP) new_mode = M_IDLE;
    else if (m_mode == M_IDLE) begin
      if (m_main < MIN && m_sec > 0) begin new_mode = M_TR; new_burst = 0; end
      else new_mode = M_IDLE;
    end else begin
      new_mode = (new_burst == LOTE || new_sec == 0 || new_main == CAP) ? M_IDLE : M_TR;
    end
    if (m_en_prev && !en) m_lot = 0;
    else if (m_drawn) begin
      m_counted++;
      if (m_lot + 1 == DUZIA * LIM) begin m_lot = 0; e_lote = 1'b1; end
      else m_lot++;
    end
    m_main = new_main; m_sec = new_sec; m_burst = new_burst; m_mode = new_mode;
    m_en_prev = en;
  endtask

  task automatic tick(input bit en, input bit lv, input int lq, input bit cons);
    enable = en; load_valid = lv; load_qty = 7'(lq); consume = cons;
    model_step(en, lv, lq, cons);
    @(posedge clk); #1;
    chk("model", dut_outs(), model_outs());
  endtask

  task automatic do_reset();
    clr = 1'b1; enable = 1'b0; load_valid = 1'b0; load_qty = 7'd0; consume = 1'b0;
    #2;
    chk("reset_async", dut_outs(), RESET_OUTS);
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic run_burst(input bit cons, output int steps);
    steps = 0;
    while (transferring === 1'b1 && steps < 60) begin
      tick(1'b1, 1'b0, 0, cons);
      steps++;
    end
  endtask

  typedef struct {
    bit en; bit lv; int lq; bit cons;
    int e_main; int e_sec; bit e_ack; bit e_err; bit e_nc; bit e_tr; bit e_ro; bit e_low;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lotes;
    int cyc;
    logic [31:0] got;
    logic [31:0] want;

    // Load limits in STOP, then a short burst with consume, then a stop.
    tbl[0]  = '{1'b0, 1'b1, 95, 1'b0,  0, 95, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1,  5, 1'b0,  0, 95, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1,  4, 1'b0,  0, 99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1,  0, 1'b0,  0, 99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1,  1, 1'b0,  0, 99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0,  0, 1'b1,  0, 99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0,  0, 1'b0,  0, 99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0,  0, 1'b0,  0, 99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0,  0, 1'b1,  1, 98, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0,  0, 1'b1,  1, 97, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0,  0, 1'b1,  1, 97, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0,  0, 1'b1,  1, 97, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    clr = 1'b0; enable = 1'b0; load_valid = 1'b0; load_qty = 7'd0; consume = 1'b0;
    #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].en, tbl[i].lv, tbl[i].lq, tbl[i].cons);
      got  = {18'd0, main_count, sec_count, load_ack, load_err, no_cork,
              transferring, ro, low};
      want = {18'd0, 7'(tbl[i].e_main), 7'(tbl[i].e_sec), tbl[i].e_ack, tbl[i].e_err,
              tbl[i].e_nc, tbl[i].e_tr, tbl[i].e_ro, tbl[i].e_low};
      chk($sformatf("vec%0d", i), got, want);
    end

    // Load 40, one full burst of LOTE corks.
    do_reset();
    tick(1'b1, 1'b1, 40, 1'b0);
    chk("b40_ack", 32'(load_ack), 32'd1);
    chk("b40_sec", 32'(sec_count), 32'd40);
    tick(1'b1, 1'b0, 0, 1'b0);
    chk("b40_tr", 32'(transferring), 32'd1);
    run_burst(1'b0, n);
    chk("b40_len", 32'(n), 32'd15);
    chk("b40_main", 32'(main_count), 32'd15);
    chk("b40_sec_after", 32'(sec_count), 32'd25);
    chk("b40_low", 32'(low), 32'd0);

    // Burst cut short by an empty secondary stock.
    do_reset();
    tick(1'b0, 1'b1, 5, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    run_burst(1'b0, n);
    chk("s5_len", 32'(n), 32'd5);
    tick(1'b1, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b1, 2, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    chk("s2_start", {16'd0, 1'b0, main_count, 1'b0, sec_count}, {16'd0, 8'd3, 8'd2});
    run_burst(1'b0, n);
    chk("s2_len", 32'(n), 32'd2);
    chk("s2_end", {16'd0, 1'b0, main_count, 1'b0, sec_count}, {16'd0, 8'd5, 8'd0});
    chk("s2_low", 32'(low), 32'd0);

    // Consume on every cycle of a burst: main holds, burst still counts.
    do_reset();
    tick(1'b0, 1'b1, 99, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    run_burst(1'b0, n);
    chk("c99_first_len", 32'(n), 32'd15);
    n = 0;
    while (transferring !== 1'b1 && n < 40) begin
      tick(1'b1, 1'b0, 0, 1'b1);
      n++;
    end
    chk("cb_start", {16'd0, 1'b0, main_count, 1'b0, sec_count}, {16'd0, 8'd3, 8'd84});
    run_burst(1'b1, n);
    chk("cb_len", 32'(n), 32'd15);
    chk("cb_end", {16'd0, 1'b0, main_count, 1'b0, sec_count}, {16'd0, 8'd3, 8'd69});

    // A full lot of 120 counted bottles with refills.
    do_reset();
    lotes = 0; cyc = 0;
    while (m_counted < DUZIA * LIM && cyc < 3000) begin
      tick(1'b1, (m_sec <= 80), 15, 1'b1);
      cyc++;
      if (lote_done === 1'b1) lotes++;
      if (m_drawn && m_counted == 12)  chk("duz_at_12", 32'(duzias), 32'd1);
      if (m_drawn && m_counted == 108) chk("duz_at_108", 32'(duzias), 32'd9);
      if (m_drawn && m_counted == 120) begin
        chk("lote_at_120", 32'(lote_done), 32'd1);
        chk("duz_at_120", 32'(duzias), 32'd0);
      end
    end
    tick(1'b1, 1'b0, 0, 1'b0);
    if (lote_done === 1'b1) lotes++;
    chk("lote_pulses", 32'(lotes), 32'd1);

    // Asynchronous reset in the middle of a burst.
    n = 0;
    while (transferring !== 1'b1 && n < 40) begin
      tick(1'b1, 1'b0, 0, 1'b0);
      n++;
    end
    tick(1'b1, 1'b0, 0, 1'b0);
    chk("tr_before_clr", 32'(transferring), 32'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_midburst", dut_outs(), RESET_OUTS);
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
    tick(1'b1, 1'b1, 10, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 127)),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
